writeback_stage: RTL and testbench

- Completion end of the register-file/scoreboard interface used by the issue stage.
- Accepts finished results from NUM_FU functional units through valid/ready handshakes and arbitrates them round-robin onto the single register-file write port.
- On the same cycle as each register-file write, it clears the destination's busy bit in the scoreboard.
- Output is registered: one result is retired per cycle, with one cycle of latency.

---
 rtl/writeback_stage.sv | 97 +++++++++
 tb/tb_writeback_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: round-robin arbitration of functional-unit results onto the
// single register-file write port, with a matching scoreboard busy-bit clear.
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FU         = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FU-1:0]                fu_valid_i,
    input  logic [NUM_FU*REG_ADDR_WIDTH-1:0] fu_rd_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data_i,
    output logic [NUM_FU-1:0]                fu_ready_o,
    input  logic                             wb_stall_i,
    output logic                             rf_write_en_o,
    output logic [REG_ADDR_WIDTH-1:0]        rf_addr_w_o,
    output logic [DATA_WIDTH-1:0]            rf_data_w_o,
    output logic                             sb_clear_en_o,
    output logic [REG_ADDR_WIDTH-1:0]        sb_clear_addr_o,
    output logic [31:0]                      retire_count_o
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]          r_rr_ptr;
    logic                      r_wr_en;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [31:0]               r_retire_count;

    logic                      w_found;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic [PTR_W:0]            w_sum;
    logic [PTR_W-1:0]          w_idx;
    logic [NUM_FU-1:0]         w_grant;
    logic [PTR_W-1:0]          w_next_ptr;
    logic [REG_ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0]     w_sel_data;

    // Search from rr_ptr upward, wrapping; the first valid port wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(off);
            if (w_sum >= (PTR_W+1)'(NUM_FU)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_FU);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && fu_valid_i[w_idx] && !rst && !wb_stall_i) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign fu_ready_o = w_grant;
    assign w_sel_rd   = fu_rd_i[w_gnt_idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign w_sel_data = fu_data_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_FU-1)) ? '0 : w_gnt_idx + 1'b1;

    // x0 fires are retired and counted but never write or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_wr_en        <= 1'b0;
            r_addr         <= '0;
            r_data         <= '0;
            r_retire_count <= '0;
        end else begin
            r_wr_en <= w_found && (w_sel_rd != '0);
            if (w_found) begin
                r_addr         <= w_sel_rd;
                r_data         <= w_sel_data;
                r_rr_ptr       <= w_next_ptr;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign rf_write_en_o   = r_wr_en;
    assign rf_addr_w_o     = r_addr;
    assign rf_data_w_o     = r_data;
    assign sb_clear_en_o   = r_wr_en;
    assign sb_clear_addr_o = r_addr;
    assign retire_count_o  = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage: a queue-based model predicts
// grants and register-file writes; a negedge monitor pops and compares.
module tb_writeback_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    fu_valid;
    logic [N*AW-1:0] fu_rd;
    logic [N*DW-1:0] fu_data;
    logic [N-1:0]    fu_ready;
    logic            stall;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data;
    logic            sb_en;
    logic [AW-1:0]   sb_addr;
    logic [31:0]     retire_count;

    writeback_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_FU(N)) dut (
        .clk(clk), .rst(rst),
        .fu_valid_i(fu_valid), .fu_rd_i(fu_rd), .fu_data_i(fu_data),
        .fu_ready_o(fu_ready), .wb_stall_i(stall),
        .rf_write_en_o(rf_we), .rf_addr_w_o(rf_addr), .rf_data_w_o(rf_data),
        .sb_clear_en_o(sb_en), .sb_clear_addr_o(sb_addr),
        .retire_count_o(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    int          m_ptr    = 0;
    int unsigned m_count  = 0;
    bit          m_rst_seen = 1'b1;
    bit          mon_en   = 1'b0;
    bit          off_v[N];
    logic [AW-1:0] off_rd[N];
    logic [DW-1:0] off_data[N];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int model_grant();
        if (rst || stall) return -1;
        for (int off = 0; off < N; off++) begin
            if (off_v[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    // Inputs are driven just after a negedge; grant is checked 1 time unit later.
    task automatic cycle();
        int g;
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) begin
            fu_valid[i]           = off_v[i];
            fu_rd[i*AW +: AW]     = off_rd[i];
            fu_data[i*DW +: DW]   = off_data[i];
        end
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        #1;
        check("grant", {60'd0, fu_ready}, {60'd0, eg});
        @(posedge clk);
        m_rst_seen = rst;
        if (rst) begin
            m_ptr   = 0;
            m_count = 0;
            exp_q.delete();
        end else if (g >= 0) begin
            if (off_rd[g] != '0) exp_q.push_back('{off_rd[g], off_data[g]});
            m_ptr   = (g + 1) % N;
            m_count = m_count + 1;
            off_v[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic offer(int i, logic [AW-1:0] rd, logic [DW-1:0] data);
        off_v[i]    = 1'b1;
        off_rd[i]   = rd;
        off_data[i] = data;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rf_write_en", {63'd0, rf_we}, 64'd1);
                check("rf_addr", {59'd0, rf_addr}, {59'd0, mon_e.rd});
                check("rf_data", {32'd0, rf_data}, {32'd0, mon_e.data});
                check("sb_clear_en", {63'd0, sb_en}, 64'd1);
                check("sb_clear_addr", {59'd0, sb_addr}, {59'd0, mon_e.rd});
            end else begin
                check("rf_write_en_idle", {63'd0, rf_we}, 64'd0);
                check("sb_clear_en_idle", {63'd0, sb_en}, 64'd0);
            end
            check("retire_count", {32'd0, retire_count}, {32'd0, m_count});
            if (m_rst_seen) begin
                check("reset_addr", {59'd0, rf_addr}, 64'd0);
                check("reset_data", {32'd0, rf_data}, 64'd0);
                check("reset_sb_addr", {59'd0, sb_addr}, 64'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        fu_valid = '0;
        fu_rd = '0;
        fu_data = '0;
        for (int i = 0; i < N; i++) begin
            off_v[i] = 1'b0; off_rd[i] = '0; off_data[i] = '0;
        end
        @(negedge clk);
        mon_en = 1'b1;

        // Reset with every FU offering; then continuous round-robin.
        for (int i = 0; i < N; i++) offer(i, AW'(i + 1), 32'hA000_0000 + 32'(i));
        cycle();
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++)
                if (!off_v[i]) offer(i, AW'(i + 1), $urandom);
            cycle();
        end
        for (int c = 0; c < 6; c++) cycle();

        // Single result, then x0 destination.
        offer(2, 5'd5, 32'hDEAD_BEEF);
        cycle();
        cycle();
        offer(1, 5'd0, 32'h0000_1234);
        cycle();
        cycle();

        // Bring rr_ptr to 0, then stall with FU0 and FU3 pending.
        offer(3, 5'd9, 32'h0000_0909);
        cycle();
        offer(0, 5'd10, 32'h0000_0A0A);
        offer(3, 5'd11, 32'h0000_0B0B);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        stall = 1'b0;
        for (int c = 0; c < 3; c++) cycle();

        // Reset the cycle after a fire; FU2 stays valid through reset.
        offer(1, 5'd7, 32'h0000_0777);
        cycle();
        offer(2, 5'd12, 32'h0000_0C0C);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();

        // Randomized traffic with stalls, x0 destinations and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 20);
            for (int i = 0; i < N; i++) begin
                if (!off_v[i] && $urandom_range(0, 99) < 40)
                    offer(i, ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31)), $urandom);
            end
            cycle();
        end
        rst = 1'b0;
        stall = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
